// File: rtl/rs232_pkg.sv
// Constants and drain-state encoding shared by the rs232out transmit front-end.
package rs232_pkg;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   typedef enum logic {
      IDLE = 1'b0,
      SENT = 1'b1
   } drain_state_t;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO: storage, wrapping pointers, occupancy counter, full/empty flags.
// Writes on full and reads on empty are ignored; no handshake logic lives here.
module fifo_sync #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_wr_en,
   input  logic [WIDTH-1:0]      i_wr_data,
   input  logic                  i_rd_en,
   output logic [WIDTH-1:0]      o_rd_data,
   output logic [DEPTH_LOG2:0]   o_level,
   output logic                  o_full,
   output logic                  o_empty
);

   localparam int                  DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] LVL_ONE    = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_level;
   logic                  r_full;
   logic                  r_empty;

   logic                  w_push;
   logic                  w_pop;
   logic [DEPTH_LOG2:0]   w_level_next;

   assign w_push = i_wr_en && !r_full;
   assign w_pop  = i_rd_en && !r_empty;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_level_next = r_level;
      if (w_push && !w_pop)
         w_level_next = r_level + LVL_ONE;
      else if (w_pop && !w_push)
         w_level_next = r_level - LVL_ONE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         r_level <= w_level_next;
         r_full  <= (w_level_next == FULL_LEVEL);
         r_empty <= (w_level_next == '0);
      end
   end

   // NOTE: storage is deliberately left out of reset; entries are only ever read after being written.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_level   = r_level;
   assign o_full    = r_full;
   assign o_empty   = r_empty;

endmodule

// File: rtl/rs232out_fifo.sv
// Buffered transmit front-end for rs232out: byte FIFO drained one frame at a time via we/busy.
// Optional LF -> CR LF expansion when RS232OUT_FIFO_CRLF_EN is defined.
module rs232out_fifo
   import rs232_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk25MHz,
   input  logic                  reset,
   input  logic [7:0]            wr_data,
   input  logic                  wr_en,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   output logic [7:0]            tx_data,
   output logic                  tx_we,
   input  logic                  tx_busy
);

   logic [7:0]          w_head;
   logic                w_empty;
   logic                w_full;
   logic [DEPTH_LOG2:0] w_level;
   logic                w_pop;

   drain_state_t        r_state;
   drain_state_t        w_state_next;
   logic [7:0]          r_tx_data;
   logic [7:0]          w_tx_data_next;
   logic                r_tx_we;
   logic                w_tx_we_next;
   logic                r_overflow;
`ifdef RS232OUT_FIFO_CRLF_EN
   logic                r_cr_sent;
   logic                w_cr_sent_next;
`endif

   fifo_sync #(
      .WIDTH      (8),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk        (clk25MHz),
      .reset      (reset),
      .i_wr_en    (wr_en),
      .i_wr_data  (wr_data),
      .i_rd_en    (w_pop),
      .o_rd_data  (w_head),
      .o_level    (w_level),
      .o_full     (w_full),
      .o_empty    (w_empty)
   );

   // SENT spaces pulses so rs232out has a cycle to raise busy from its registered state.
   always_comb begin
      w_state_next   = r_state;
      w_tx_we_next   = 1'b0;
      w_tx_data_next = r_tx_data;
      w_pop          = 1'b0;
`ifdef RS232OUT_FIFO_CRLF_EN
      w_cr_sent_next = r_cr_sent;
`endif
      case (r_state)
         IDLE: begin
            if (!w_empty && !tx_busy) begin
               w_tx_we_next = 1'b1;
               w_state_next = SENT;
`ifdef RS232OUT_FIFO_CRLF_EN
               if (w_head == ASCII_LF && !r_cr_sent) begin
                  w_tx_data_next = ASCII_CR;
                  w_cr_sent_next = 1'b1;
               end else begin
                  w_tx_data_next = w_head;
                  w_pop          = 1'b1;
                  w_cr_sent_next = 1'b0;
               end
`else
               w_tx_data_next = w_head;
               w_pop          = 1'b1;
`endif
            end
         end
         SENT:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk25MHz) begin
      if (reset) begin
         r_state    <= IDLE;
         r_tx_data  <= 8'h00;
         r_tx_we    <= 1'b0;
         r_overflow <= 1'b0;
`ifdef RS232OUT_FIFO_CRLF_EN
         r_cr_sent  <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_next;
         r_tx_data <= w_tx_data_next;
         r_tx_we   <= w_tx_we_next;
         if (wr_en && w_full)
            r_overflow <= 1'b1;
`ifdef RS232OUT_FIFO_CRLF_EN
         r_cr_sent <= w_cr_sent_next;
`endif
      end
   end

   assign full     = w_full;
   assign level    = w_level;
   assign overflow = r_overflow;
   assign tx_data  = r_tx_data;
   assign tx_we    = r_tx_we;

endmodule
